multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle successor to the single-cycle RISC-V main decoder. It sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states. Instruction and data accesses share one memory with a ready handshake, and a bounded wait timeout is enforced. The block sits between the instruction register and the shared-memory datapath, and drives the same control strobes as before plus PC/IR write enables, jump control and a sticky fault flag.

## Interface
- HAS_JUMP, default 1: when 1, decode JAL (1101111) and JALR (1100111); when 0, these opcodes are illegal.
- MEM_TIMEOUT, default 15: maximum consecutive request cycles without `mem_ready` before FAULT; 0 disables the timeout.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current fetch, read or write this cycle.
- InstrReq  out  1  instruction fetch request.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update the PC (PC+4, or target when Branch/Jump applies).
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  same meaning as the single-cycle decoder.
- ALUOp  out  2  00 LW/SW/LUI/JAL/JALR, 01 BR, 10 R/I.
- Jump  out  1  PC target from the jump path; write data is PC+4.
- Fault  out  1  sticky; illegal opcode or memory timeout.
- State  out  3  current state encoding, for debug.

## Operation
- Supported opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, LUI 0110111, plus JAL/JALR when HAS_JUMP=1.
- Instruction class is latched on the DECODE cycle. Later changes to `Opcode` have no effect until the next DECODE.
- FETCH: InstrReq=1. On `mem_ready`: IRWrite=1 in the same cycle, then go to DECODE.
- DECODE: no strobes. Illegal opcode goes to FAULT; otherwise go to EXECUTE.
- EXECUTE:
  - ALUOp and ALUSrc are driven per class, matching the single-cycle values.
  - BR: Branch=1 and PCWrite=1, then go to FETCH.
  - LW/SW: go to MEMORY.
  - R/I/LUI: go to WRITEBACK.
  - JAL/JALR: Jump=1, then go to WRITEBACK.
- MEMORY: MemRead (LW) or MemWrite (SW) is held until `mem_ready`.
  - LW then goes to WRITEBACK.
  - SW asserts PCWrite=1 in its `mem_ready` cycle, then goes to FETCH.
- WRITEBACK: RegWrite=1 and PCWrite=1 for one cycle.
  - MemtoReg=1 for LW.
  - Jump stays 1 for JAL/JALR so the datapath selects the link value and jump target.
  - Then go to FETCH.
- FAULT: all strobes 0 and Fault=1. Only reset exits this state.
- Wait counter, width $clog2(MEM_TIMEOUT+1):
  - Cleared on entry to FETCH or MEMORY, and on `mem_ready`.
  - Increments each request cycle with `mem_ready` low.
  - Reaching MEM_TIMEOUT with `mem_ready` low sends the next state to FAULT.
  - `mem_ready` in that same cycle wins: the access completes normally.
- All strobes are pulses tied to the state; no strobe is asserted outside its listed state.

## Timing
- While reset is high: state=FETCH, counter=0, class=NONE, and every output is 0, including Fault and State=0.
- First cycle after reset release: FETCH with InstrReq=1.
- Minimum cycles per instruction with `mem_ready` always high: BR 3, R/I/LUI/SW/JAL/JALR 4, LW 5.
- Each cycle of `mem_ready` low in FETCH or MEMORY adds one cycle.
- Reset asserted mid-instruction aborts it immediately. No strobe is asserted after reset rises.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state enum: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT.
  - opcode localparams.
  - class enum: NONE, R, I, LW, SW, BR, LUI, JAL, JALR.
  - ALUOp constants.
- Sub-module `opcode_class_decode`: combinational Opcode + HAS_JUMP → class and legal flag.
- The FSM, wait counter and output decode live in the top module.

## Test plan
- R-type 0110011 with `mem_ready`=1 → IRWrite at cycle 0; RegWrite=1, PCWrite=1, ALUOp=10 at cycle 3; back in FETCH at cycle 4.
- LW with `mem_ready` low for 2 MEMORY cycles → MemRead held 3 cycles; WRITEBACK with MemtoReg=1; 7 cycles total.
- BR 1100011 → Branch=1, PCWrite=1, ALUOp=01 in EXECUTE; RegWrite never asserted; 3 cycles.
- MEM_TIMEOUT=4, `mem_ready` stuck low in FETCH → Fault=1 after 4 request cycles and stays 1. Same run with `mem_ready` high on the 4th cycle → normal DECODE.
- HAS_JUMP=0 with JAL → FAULT after DECODE. HAS_JUMP=1 with JAL → Jump=1 in EXECUTE and WRITEBACK, RegWrite=1 in WRITEBACK.
- Reset asserted in MEMORY during SW → MemWrite drops the same cycle, all outputs 0; InstrReq=1 in the first cycle after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, instruction classes, opcodes and ALUOp encodings for the multicycle controller
package riscv_ctrl_pkg;
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        FAULT     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_LUI,
        CLS_JAL,
        CLS_JALR
    } class_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

    // ALU operation selector for a class, same values as the single-cycle decoder
    function automatic logic [1:0] class_alu_op(class_t c);
        return c == CLS_BR ? ALUOP_BR : (c == CLS_R || c == CLS_I) ? ALUOP_RI : ALUOP_ADD;
    endfunction

    // immediate operand selection: everything that adds rs1 (or nothing) to an immediate
    function automatic logic class_alu_src(class_t c);
        return c == CLS_I || c == CLS_LW || c == CLS_SW || c == CLS_LUI || c == CLS_JALR;
    endfunction
endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode: maps a 7-bit opcode to an instruction class and a legal flag
module opcode_class_decode
    import riscv_ctrl_pkg::*;
#(
    parameter bit HAS_JUMP = 1'b1
) (
    input  logic [6:0] opcode,
    output class_t     cls,
    output logic       legal
);
    assign cls = opcode == OP_R   ? CLS_R   :
                 opcode == OP_I   ? CLS_I   :
                 opcode == OP_LW  ? CLS_LW  :
                 opcode == OP_SW  ? CLS_SW  :
                 opcode == OP_BR  ? CLS_BR  :
                 opcode == OP_LUI ? CLS_LUI :
                 (HAS_JUMP && opcode == OP_JAL)  ? CLS_JAL  :
                 (HAS_JUMP && opcode == OP_JALR) ? CLS_JALR :
                 CLS_NONE;
    assign legal = cls != CLS_NONE;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with shared-memory handshake and wait timeout
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit          HAS_JUMP    = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    output logic       InstrReq,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       Jump,
    output logic       Fault,
    output logic [2:0] State
);
    localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t        state, state_d;
    class_t        cls, cls_d, dec_cls;
    logic          dec_legal;
    logic [CW-1:0] cnt, cnt_d;
    logic          req, timeout, is_jump;
    logic          instr_req, ir_write, pc_write, alu_src, mem_to_reg, reg_write;
    logic          mem_read, mem_write, branch, jump, fault;
    logic [1:0]    alu_op;

    opcode_class_decode #(.HAS_JUMP(HAS_JUMP)) u_dec (
        .opcode(Opcode),
        .cls   (dec_cls),
        .legal (dec_legal)
    );

    assign req     = state == FETCH || state == MEMORY;
    assign timeout = MEM_TIMEOUT != 0 && req && !mem_ready && cnt == CNT_LAST;
    assign cnt_d   = req && !mem_ready ? cnt + 1'b1 : '0;
    assign is_jump = cls == CLS_JAL || cls == CLS_JALR;

    // state, latched class and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            cls   <= CLS_NONE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cls   <= cls_d;
            cnt   <= cnt_d;
        end
    end

    // next state and per-state strobes; ALU steering holds from EXECUTE through WRITEBACK
    always_comb begin
        state_d    = state;
        cls_d      = cls;
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        fault      = 1'b0;
        alu_op     = ALUOP_ADD;
        case (state)
            FETCH: begin
                instr_req = 1'b1;
                ir_write  = mem_ready;
                state_d   = mem_ready ? DECODE : timeout ? FAULT : FETCH;
            end
            DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_legal ? EXECUTE : FAULT;
            end
            EXECUTE: begin
                alu_op   = class_alu_op(cls);
                alu_src  = class_alu_src(cls);
                branch   = cls == CLS_BR;
                pc_write = cls == CLS_BR;
                jump     = is_jump;
                state_d  = cls == CLS_BR ? FETCH : (cls == CLS_LW || cls == CLS_SW) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                alu_op    = class_alu_op(cls);
                alu_src   = class_alu_src(cls);
                mem_read  = cls == CLS_LW;
                mem_write = cls == CLS_SW;
                pc_write  = mem_ready && cls == CLS_SW;
                state_d   = mem_ready ? (cls == CLS_LW ? WRITEBACK : FETCH) : timeout ? FAULT : MEMORY;
            end
            WRITEBACK: begin
                alu_op     = class_alu_op(cls);
                alu_src    = class_alu_src(cls);
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = cls == CLS_LW;
                jump       = is_jump;
                state_d    = FETCH;
            end
            FAULT: fault = 1'b1;
            default: state_d = FAULT;
        endcase
    end

    assign {InstrReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump, Fault, State} =
        reset ? '0 : {instr_req, ir_write, pc_write, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, jump, fault, state};
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table, hand-written and random instruction streams checked against a phase-level model
module tb_multicycle_controller;
    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_LUI = 6, K_JAL = 7, K_JALR = 8;
    localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LW = 7'b0000011, O_SW = 7'b0100011;
    localparam logic [6:0] O_BR = 7'b1100011, O_LUI = 7'b0110111, O_JAL = 7'b1101111, O_JALR = 7'b1100111;

    typedef struct packed {
        logic       instr_req;
        logic       ir_write;
        logic       pc_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       fault;
    } outs_t;

    typedef struct {
        bit         sel;
        logic [6:0] op;
        int         fw;
        int         mw;
        bit         exp_fault;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [6:0] opcode = '0;
    logic       mem_ready = 1'b0;
    bit         sel = 1'b0;
    wire [12:0] va, vb;
    wire [2:0]  sa, sb;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HAS_JUMP(1'b1), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(rst_a), .Opcode(opcode), .mem_ready(mem_ready),
        .InstrReq(va[12]), .IRWrite(va[11]), .PCWrite(va[10]), .ALUSrc(va[9]), .MemtoReg(va[8]),
        .RegWrite(va[7]), .MemRead(va[6]), .MemWrite(va[5]), .Branch(va[4]), .ALUOp(va[3:2]),
        .Jump(va[1]), .Fault(va[0]), .State(sa)
    );

    multicycle_controller #(.HAS_JUMP(1'b0), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(rst_b), .Opcode(opcode), .mem_ready(mem_ready),
        .InstrReq(vb[12]), .IRWrite(vb[11]), .PCWrite(vb[10]), .ALUSrc(vb[9]), .MemtoReg(vb[8]),
        .RegWrite(vb[7]), .MemRead(vb[6]), .MemWrite(vb[5]), .Branch(vb[4]), .ALUOp(vb[3:2]),
        .Jump(vb[1]), .Fault(vb[0]), .State(sb)
    );

    task automatic check(input string name, input outs_t e);
        outs_t g;
        g = sel ? vb : va;
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s dut=%0d t=%0t got=%b exp=%b", name, sel, $time, g, e);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] e);
        logic [2:0] g;
        g = sel ? sb : sa;
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s dut=%0d t=%0t got=%0d exp=%0d", name, sel, $time, g, e);
        end
    endtask

    task automatic step(input logic rdy, input logic [6:0] op, input outs_t e, input string name);
        mem_ready = rdy;
        opcode = op;
        @(negedge clk);
        check(name, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit s);
        sel = s;
        mem_ready = 1'b1;
        opcode = O_R;
        if (s) rst_b = 1'b1; else rst_a = 1'b1;
        #1;
        check("reset_outs", '0);
        check_state("reset_state", 3'd0);
        @(posedge clk);
        #1;
        check("reset_hold", '0);
        if (s) rst_b = 1'b0; else rst_a = 1'b0;
    endtask

    function automatic int kind_of(input logic [6:0] op, input bit hj);
        return op == O_R ? K_R : op == O_I ? K_I : op == O_LW ? K_LW : op == O_SW ? K_SW :
               op == O_BR ? K_BR : op == O_LUI ? K_LUI :
               (hj && op == O_JAL) ? K_JAL : (hj && op == O_JALR) ? K_JALR : K_ILL;
    endfunction

    task automatic fault_tail();
        outs_t f;
        f = '0;
        f.fault = 1'b1;
        repeat (3) step(1'($urandom), 7'($urandom), f, "fault_sticky");
    endtask

    // one instruction: fw wait cycles before the fetch completes, mw before the memory access completes
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, output bit faulted);
        int    k, to;
        outs_t e, base;
        to = sel ? 0 : 4;
        k = kind_of(op, !sel);
        faulted = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            e.instr_req = 1'b1;
            if (i == fw) begin
                e.ir_write = 1'b1;
                step(1'b1, 7'($urandom), e, "fetch_done");
            end else begin
                step(1'b0, 7'($urandom), e, "fetch_wait");
                if (to != 0 && i + 1 == to) begin
                    fault_tail();
                    faulted = 1'b1;
                    return;
                end
            end
        end
        step(1'($urandom), op, '0, "decode");
        if (k == K_ILL) begin
            fault_tail();
            faulted = 1'b1;
            return;
        end
        base = '0;
        base.alu_op = k == K_BR ? 2'b01 : (k == K_R || k == K_I) ? 2'b10 : 2'b00;
        base.alu_src = k == K_I || k == K_LW || k == K_SW || k == K_LUI || k == K_JALR;
        e = base;
        e.branch = k == K_BR;
        e.pc_write = k == K_BR;
        e.jump = k == K_JAL || k == K_JALR;
        step(1'($urandom), 7'($urandom), e, "execute");
        if (k == K_BR) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                e = base;
                e.mem_read = k == K_LW;
                e.mem_write = k == K_SW;
                if (i == mw) begin
                    e.pc_write = k == K_SW;
                    step(1'b1, 7'($urandom), e, "memory_done");
                end else begin
                    step(1'b0, 7'($urandom), e, "memory_wait");
                    if (to != 0 && i + 1 == to) begin
                        fault_tail();
                        faulted = 1'b1;
                        return;
                    end
                end
            end
            if (k == K_SW) return;
        end
        e = base;
        e.reg_write = 1'b1;
        e.pc_write = 1'b1;
        e.mem_to_reg = k == K_LW;
        e.jump = k == K_JAL || k == K_JALR;
        step(1'($urandom), 7'($urandom), e, "writeback");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[18];
        logic [6:0] ops[9];
        outs_t      e;
        bit         f, prev_fault;
        tbl = '{
            '{0, O_R, 0, 0, 0}, '{0, O_I, 1, 0, 0}, '{0, O_LW, 0, 2, 0}, '{0, O_SW, 1, 1, 0},
            '{0, O_BR, 0, 0, 0}, '{0, O_LUI, 2, 0, 0}, '{0, O_JAL, 0, 0, 0}, '{0, O_JALR, 0, 3, 0},
            '{0, O_R, 3, 0, 0}, '{0, O_LW, 0, 3, 0}, '{0, O_R, 4, 0, 1}, '{0, O_SW, 0, 4, 1},
            '{0, 7'b1111111, 0, 0, 1}, '{1, O_JAL, 0, 0, 1}, '{1, O_JALR, 0, 0, 1},
            '{1, O_R, 20, 0, 0}, '{1, O_LW, 5, 20, 0}, '{1, O_SW, 0, 0, 0}
        };
        ops = '{O_R, O_I, O_LW, O_SW, O_BR, O_LUI, O_JAL, O_JALR, O_BR};
        do_reset(1'b0);
        prev_fault = 1'b0;
        foreach (tbl[i]) begin
            if (prev_fault || tbl[i].sel != sel) do_reset(tbl[i].sel);
            run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, f);
            mem_ready = 1'b0;
            #2;
            e = '0;
            if (tbl[i].exp_fault) e.fault = 1'b1; else e.instr_req = 1'b1;
            check("table_end", e);
            prev_fault = f;
        end

        // reset arriving while a store waits in MEMORY
        do_reset(1'b0);
        e = '0; e.instr_req = 1'b1; e.ir_write = 1'b1;
        step(1'b1, 7'($urandom), e, "sw_fetch");
        step(1'b0, O_SW, '0, "sw_decode");
        e = '0; e.alu_src = 1'b1;
        step(1'b0, 7'($urandom), e, "sw_execute");
        mem_ready = 1'b0;
        #1;
        e.mem_write = 1'b1;
        check("sw_memory", e);
        rst_a = 1'b1;
        #1;
        check("sw_abort", '0);
        check_state("sw_abort_state", 3'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        e = '0; e.instr_req = 1'b1;
        step(1'b0, 7'($urandom), e, "sw_restart");

        do_reset(1'b0);
        repeat (60) begin
            int r;
            r = $urandom_range(0, 9);
            run_instr(r == 9 ? 7'($urandom) : ops[r], $urandom_range(0, 5), $urandom_range(0, 5), f);
            if (f) do_reset(1'b0);
        end
        do_reset(1'b1);
        repeat (20) begin
            int r;
            r = $urandom_range(0, 8);
            run_instr(ops[r], $urandom_range(0, 8), $urandom_range(0, 8), f);
            if (f) do_reset(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
